ahb2_sram_slave: RTL and testbench
==================================

# ahb2_sram_slave

AMBA2 AHB (ARM IHI 0011A) slave that answers transfers from an AHB2 master with a byte-addressable on-chip SRAM. It sits behind the AHB2 decoder/mux on the slave side of the `AHB2_INTF` bus. It implements the address/data-phase pipeline, programmable wait states, the two-cycle ERROR response, and write-to-read forwarding.

## Interface
- `ADDR_WIDTH`, 32, haddr width
- `DATA_WIDTH`, 32, hwdata/hrdata width; 32 or 64
- `MEM_DEPTH`, 1024, SRAM depth in `DATA_WIDTH` words
- `WAIT_STATES`, 0, hreadyout-low cycles inserted per OKAY data phase; 0..15
- `hclk  in  1`  bus clock, all state on rising edge
- `hreset  in  1`  asynchronous, active-high reset
- `hsel  in  1`  slave select from decoder
- `haddr  in  ADDR_WIDTH`  transfer address
- `htrans  in  2`  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- `hwrite  in  1`  1 = write
- `hsize  in  3`  bytes = 2^hsize
- `hburst  in  3`  burst type; informational only, no address prediction
- `hprot  in  4`  protection; only bit 1 is used, and only with the macro
- `hwdata  in  DATA_WIDTH`  write data, valid in data phase
- `hready  in  1`  bus-wide ready; an address phase is sampled only when high
- `hreadyout  out  1`  this slave's ready
- `hresp  out  2`  OKAY=0, ERROR=1; RETRY and SPLIT are never driven
- `hrdata  out  DATA_WIDTH`  read data

## Operation
- **Accept:** `hsel & hready & htrans[1]` at a rising edge registers addr, size, write and lane mask.
- **IDLE/BUSY or unselected:** zero-wait OKAY; no state change.
- **Error check at accept (any one gives ERROR):**
  - `hsize` > log2(DATA_WIDTH/8)
  - `haddr` not aligned to `hsize`
  - word index ≥ `MEM_DEPTH`
- **Error effect:** no memory access occurs.
- **Byte lanes:** little-endian, derived from `haddr[log2(DATA_WIDTH/8)-1:0]` and `hsize`.
- **Writes:** commit `hwdata` under the lane mask at the final data-phase edge (hreadyout=1).
- **Reads:** the array is read at accept. `hrdata` is valid in the final data-phase cycle and holds its value until the next read completes.
- **Forwarding:** a read accepted in the same edge as a preceding write's commit to the same word returns the merged new bytes.
- **FSM states:**
  - `IDLE`: hreadyout=1.
  - `WAIT`: counter loads `WAIT_STATES`; hreadyout=0 while count≠0.
  - `ERR1`: hreadyout=0, hresp=ERROR.
  - `ERR2`: hreadyout=1, hresp=ERROR.
- **Transitions:**
  - Accept OKAY with WAIT_STATES=0 → `IDLE` (data phase completes next cycle).
  - Accept OKAY with WAIT_STATES>0 → `WAIT`, then `IDLE` when the count reaches 0.
  - Accept error → `ERR1` → `ERR2`.
  - In `ERR2`, a new accept is legal. A master cancelling to IDLE is ordinary IDLE.
- **Reset:**
  - Values: hreadyout=1, hresp=OKAY, hrdata=0, FSM=`IDLE`, counter=0.
  - Reset mid-phase drops any pending write.
  - SRAM contents are not reset.

## Timing
- Address accepted at edge T.
- Data phase spans cycles T..T+WAIT_STATES; hreadyout rises in cycle T+WAIT_STATES.
- Write lands at edge T+WAIT_STATES+1.
- Back-to-back zero-wait NONSEQ/SEQ sustain 1 transfer per cycle.
- ERROR always occupies exactly 2 data-phase cycles, independent of `WAIT_STATES`.
- Accept is never taken while hreadyout=0, because hready is low then.

## Configuration
- `AHB2_SRAM_PROT_EN` defined:
  - A write with `hprot[1]=0` (user) to the upper half of the array (word index ≥ MEM_DEPTH/2) takes the two-cycle ERROR, and the memory is unchanged.
  - Reads are unaffected.
- Undefined: `hprot` is ignored entirely.

## Structure
- **Package `ahb2_pkg`:**
  - `htrans_t`, `hresp_t`, `hsize_t`, `hburst_t` enums
  - `slv_state_t` (IDLE, WAIT, ERR1, ERR2)
  - encoding constants
- **Sub-module `ahb2_sram_mem`:**
  - 1R1W byte-enabled array of `MEM_DEPTH` × `DATA_WIDTH`, synchronous read.
  - Forwarding mux lives in the parent.

## Test plan
- Reset asserted mid-WAIT with WAIT_STATES=3 → next cycle hreadyout=1, hresp=0, hrdata=0.
- NONSEQ word write 0xDEADBEEF @0x10, then NONSEQ read @0x10, zero-wait → hrdata=0xDEADBEEF in the cycle after the read's address phase; forwarding path exercised.
- Byte write 0xAA @0x13 over word 0x11223344 → read @0x10 returns 0xAA223344.
- WAIT_STATES=2, read @0x0 → hreadyout low 2 cycles, high in 3rd with data; next SEQ accepted that cycle.
- Misaligned halfword read @0x01, then read @(MEM_DEPTH*4) → each gives hreadyout 0/1 with hresp=ERROR both cycles; memory untouched.
- With `AHB2_SRAM_PROT_EN`, write with hprot=0x1 to word MEM_DEPTH-1 → ERROR and the old data persists; the same write with hprot=0x3 → OKAY.

Source files
------------

// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings and slave FSM state type for the SRAM slave.
package ahb2_pkg;

  localparam int unsigned HTRANS_W = 2;
  localparam int unsigned HRESP_W  = 2;
  localparam int unsigned HSIZE_W  = 3;
  localparam int unsigned HBURST_W = 3;
  localparam int unsigned HPROT_W  = 4;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    RespOkay  = 2'd0,
    RespError = 2'd1,
    RespRetry = 2'd2,
    RespSplit = 2'd3
  } hresp_t;

  typedef enum logic [2:0] {
    SizeByte   = 3'd0,
    SizeHalf   = 3'd1,
    SizeWord   = 3'd2,
    SizeDword  = 3'd3,
    Size4Word  = 3'd4,
    Size8Word  = 3'd5,
    Size16Word = 3'd6,
    Size32Word = 3'd7
  } hsize_t;

  typedef enum logic [2:0] {
    BurstSingle = 3'd0,
    BurstIncr   = 3'd1,
    BurstWrap4  = 3'd2,
    BurstIncr4  = 3'd3,
    BurstWrap8  = 3'd4,
    BurstIncr8  = 3'd5,
    BurstWrap16 = 3'd6,
    BurstIncr16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StErr1 = 2'd2,
    StErr2 = 2'd3
  } slv_state_t;

endpackage

// File: rtl/ahb2_sram_slave_if.sv
// AHB2 slave-side bus bundle; master modport drives requests (and the muxed hready).
interface ahb2_sram_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic [1:0]            hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb2_sram_mem.sv
// 1R1W byte-enabled SRAM array with synchronous read; contents are never reset.
module ahb2_sram_mem #(
  parameter int unsigned Depth     = 1024,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned IdxW     = $clog2(Depth),
  localparam int unsigned NumBytes = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 re_i,
  input  logic [IdxW-1:0]      raddr_i,
  output logic [DataWidth-1:0] rdata_o,
  input  logic                 we_i,
  input  logic [IdxW-1:0]      waddr_i,
  input  logic [NumBytes-1:0]  wbe_i,
  input  logic [DataWidth-1:0] wdata_i
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  // Byte-masked write and read-before-write synchronous read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb2_sram_slave.sv
// AHB2 SRAM slave: address/data pipeline, wait states, two-cycle ERROR, write-to-read
// forwarding. Optional AHB2_SRAM_PROT_EN blocks user-mode writes to the upper half.
module ahb2_sram_slave
  import ahb2_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic              hclk,
  input logic              hreset,
  ahb2_sram_slave_if.slave bus
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(MEM_DEPTH);

  slv_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hreadyout;
  hresp_t     hresp;

  logic                  accept, req_err, acc_ok, we;
  logic [ADDR_WIDTH-1:0] size_mask, word_addr;
  int unsigned           off, nbytes;
  logic [NumBytes-1:0]   lane_d;
  logic [IdxW-1:0]       new_idx;

  logic                  wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumBytes-1:0]   mask_q, mask_d, fwd_mask_q, fwd_mask_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d, hrdata_q, hrdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata, fwd_bits, merged;

  logic unused_bus;
  assign unused_bus = ^{bus.hburst, bus.hprot, bus.htrans[0]};

  // Only sample a new address phase while this slave is ready.
  assign hreadyout = (state_q == StIdle) || (state_q == StErr2);
  assign hresp     = ((state_q == StErr1) || (state_q == StErr2)) ? RespError : RespOkay;
  assign accept    = bus.hsel & bus.hready & bus.htrans[1] & hreadyout;
  assign acc_ok    = accept & ~req_err;
  assign new_idx   = bus.haddr[OffW +: IdxW];
  assign we        = wr_pend_q & hreadyout;

  // Request legality and little-endian byte-lane decode.
  always_comb begin
    size_mask = (ADDR_WIDTH'(1) << bus.hsize) - ADDR_WIDTH'(1);
    word_addr = bus.haddr >> OffW;
    req_err   = (bus.hsize > 3'(OffW)) || ((bus.haddr & size_mask) != '0) ||
                (word_addr >= ADDR_WIDTH'(MEM_DEPTH));
`ifdef AHB2_SRAM_PROT_EN
    if (bus.hwrite && !bus.hprot[1] && (word_addr >= ADDR_WIDTH'(MEM_DEPTH / 2))) begin
      req_err = 1'b1;
    end
`endif
    off    = 32'(bus.haddr[OffW-1:0]);
    nbytes = 32'd1 << bus.hsize;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      lane_d[b] = (b >= off) && (b < off + nbytes);
    end
  end

  // FSM next state: wait-state countdown and the fixed two-cycle error response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1: state_d = StErr2;
      StIdle, StErr2: begin
        state_d = StIdle;
        if (accept) begin
          if (req_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES != 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Data-phase bookkeeping; forwarding captures bytes committed at the read's accept edge.
  always_comb begin
    wr_pend_d  = wr_pend_q;
    rd_pend_d  = rd_pend_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;
    hrdata_d   = (rd_pend_q && hreadyout) ? merged : hrdata_q;
    if (hreadyout) begin
      wr_pend_d = acc_ok & bus.hwrite;
      rd_pend_d = acc_ok & ~bus.hwrite;
    end
    if (acc_ok) begin
      idx_d  = new_idx;
      mask_d = lane_d;
      if (!bus.hwrite) begin
        fwd_mask_d = (we && (idx_q == new_idx)) ? mask_q : '0;
        fwd_data_d = bus.hwdata;
      end
    end
  end

  // Merge forwarded bytes over the (pre-write) array read.
  always_comb begin
    for (int unsigned b = 0; b < NumBytes; b++) begin
      fwd_bits[8*b +: 8] = {8{fwd_mask_q[b]}};
    end
    merged = (mem_rdata & ~fwd_bits) | (fwd_data_q & fwd_bits);
  end

  // State registers; reset drops any pending write.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      idx_q      <= '0;
      mask_q     <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
      hrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
      hrdata_q   <= hrdata_d;
    end
  end

  ahb2_sram_mem #(
    .Depth     (MEM_DEPTH),
    .DataWidth (DATA_WIDTH)
  ) u_mem (
    .clk_i   (hclk),
    .re_i    (acc_ok & ~bus.hwrite),
    .raddr_i (new_idx),
    .rdata_o (mem_rdata),
    .we_i    (we),
    .waddr_i (idx_q),
    .wbe_i   (mask_q),
    .wdata_i (bus.hwdata)
  );

  assign bus.hreadyout = hreadyout;
  assign bus.hresp     = hresp;
  assign bus.hrdata    = (rd_pend_q && hreadyout) ? merged : hrdata_q;

endmodule

// File: tb/tb_ahb2_sram_slave.sv
// Directed bench: three slaves (0, 2 and 3 wait states) share one driver; tgt selects which.
module tb_ahb2_sram_slave;
  import ahb2_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MD = 1024;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [1:0]    tgt;
  logic          sel;
  logic [1:0]    trans;
  logic [AW-1:0] addr;
  logic          wr;
  logic [2:0]    size;
  logic [3:0]    prot;
  logic [DW-1:0] wdata;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic          ro;
  logic [1:0]    rs;
  logic [DW-1:0] rd;

  always #5 hclk = ~hclk;

  ahb2_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
  ahb2_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b2 ();
  ahb2_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b3 ();

  assign b0.hsel = sel & (tgt == 2'd0);
  assign b2.hsel = sel & (tgt == 2'd2);
  assign b3.hsel = sel & (tgt == 2'd3);
  assign b0.haddr = addr;  assign b2.haddr = addr;  assign b3.haddr = addr;
  assign b0.htrans = trans; assign b2.htrans = trans; assign b3.htrans = trans;
  assign b0.hwrite = wr;   assign b2.hwrite = wr;   assign b3.hwrite = wr;
  assign b0.hsize = size;  assign b2.hsize = size;  assign b3.hsize = size;
  assign b0.hburst = 3'd0; assign b2.hburst = 3'd0; assign b3.hburst = 3'd0;
  assign b0.hprot = prot;  assign b2.hprot = prot;  assign b3.hprot = prot;
  assign b0.hwdata = wdata; assign b2.hwdata = wdata; assign b3.hwdata = wdata;
  assign b0.hready = b0.hreadyout;
  assign b2.hready = b2.hreadyout;
  assign b3.hready = b3.hreadyout;

  ahb2_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(MD), .WAIT_STATES(0)) u_dut0 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (b0)
  );
  ahb2_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(MD), .WAIT_STATES(2)) u_dut2 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (b2)
  );
  ahb2_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(MD), .WAIT_STATES(3)) u_dut3 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (b3)
  );

  always_comb begin
    ro = b0.hreadyout;
    rs = b0.hresp;
    rd = b0.hrdata;
    case (tgt)
      2'd2: begin ro = b2.hreadyout; rs = b2.hresp; rd = b2.hrdata; end
      2'd3: begin ro = b3.hreadyout; rs = b3.hresp; rd = b3.hrdata; end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] t, input logic [AW-1:0] a,
                       input logic w, input logic [2:0] sz, input logic [3:0] p);
    sel = s; trans = t; addr = a; wr = w; size = sz; prot = p;
  endtask

  task automatic idle();
    drive(1'b1, TransIdle, '0, 1'b0, SizeWord, 4'h3);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic e_rdy, input logic [1:0] e_resp);
    chk({tag, "_rdy"}, {31'd0, ro}, {31'd0, e_rdy});
    chk({tag, "_resp"}, {30'd0, rs}, {30'd0, e_resp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    hreset = 1'b1;
    tgt    = 2'd0;
    wdata  = '0;
    idle();
    step();
    step();
    chk_bus("reset", 1'b1, 2'd0);
    chk("reset_hrdata", rd, 32'h0);
    hreset = 1'b0;
    step();

    // Word write then back-to-back read of the same word (forwarded).
    drive(1'b1, TransNonseq, 32'h10, 1'b1, SizeWord, 4'h3);
    step();
    wdata = 32'hDEADBEEF;
    drive(1'b1, TransNonseq, 32'h10, 1'b0, SizeWord, 4'h3);
    chk_bus("wr0_dp", 1'b1, 2'd0);
    step();
    idle();
    chk("fwd_rd", rd, 32'hDEADBEEF);
    chk_bus("fwd_rd", 1'b1, 2'd0);
    step();
    chk("rd_hold", rd, 32'hDEADBEEF);

    // Byte write to lane 3 over 0x11223344, read back forwarded then from the array.
    drive(1'b1, TransNonseq, 32'h10, 1'b1, SizeWord, 4'h3);
    step();
    wdata = 32'h11223344;
    drive(1'b1, TransNonseq, 32'h13, 1'b1, SizeByte, 4'h3);
    step();
    wdata = 32'hAA000000;
    drive(1'b1, TransNonseq, 32'h10, 1'b0, SizeWord, 4'h3);
    step();
    idle();
    chk("byte_fwd", rd, 32'hAA223344);
    step();
    drive(1'b1, TransNonseq, 32'h10, 1'b0, SizeWord, 4'h3);
    step();
    idle();
    chk("byte_rd", rd, 32'hAA223344);
    step();

    // Unselected and BUSY transfers must not write.
    drive(1'b0, TransNonseq, 32'h10, 1'b1, SizeWord, 4'h3);
    wdata = 32'h0;
    step();
    drive(1'b1, TransBusy, 32'h10, 1'b1, SizeWord, 4'h3);
    chk_bus("unsel", 1'b1, 2'd0);
    step();
    idle();
    chk_bus("busy", 1'b1, 2'd0);
    step();
    drive(1'b1, TransNonseq, 32'h10, 1'b0, SizeWord, 4'h3);
    step();
    idle();
    chk("no_wr", rd, 32'hAA223344);
    step();

    // Misaligned halfword read, then out-of-range read accepted in ERR2.
    drive(1'b1, TransNonseq, 32'h01, 1'b0, SizeHalf, 4'h3);
    step();
    idle();
    chk_bus("mis_e1", 1'b0, 2'd1);
    step();
    chk_bus("mis_e2", 1'b1, 2'd1);
    drive(1'b1, TransNonseq, MD * 4, 1'b0, SizeWord, 4'h3);
    step();
    idle();
    chk_bus("oor_e1", 1'b0, 2'd1);
    chk("err_hold", rd, 32'hAA223344);
    step();
    chk_bus("oor_e2", 1'b1, 2'd1);
    step();
    chk_bus("err_done", 1'b1, 2'd0);

    // Misaligned and oversize writes leave memory untouched.
    drive(1'b1, TransNonseq, 32'h12, 1'b1, SizeWord, 4'h3);
    step();
    wdata = 32'h55555555;
    idle();
    chk_bus("wmis_e1", 1'b0, 2'd1);
    step();
    drive(1'b1, TransNonseq, 32'h10, 1'b1, SizeDword, 4'h3);
    step();
    idle();
    chk_bus("wsz_e1", 1'b0, 2'd1);
    step();
    step();
    drive(1'b1, TransNonseq, 32'h10, 1'b0, SizeWord, 4'h3);
    step();
    idle();
    chk("err_nowr", rd, 32'hAA223344);
    step();

    // Protection on the top word (index MD-1).
    drive(1'b1, TransNonseq, (MD - 1) * 4, 1'b1, SizeWord, 4'h3);
    step();
    wdata = 32'h12345678;
    drive(1'b1, TransNonseq, (MD - 1) * 4, 1'b1, SizeWord, 4'h1);
    chk_bus("p_pre", 1'b1, 2'd0);
    step();
    wdata = 32'hCAFEF00D;
    idle();
`ifdef AHB2_SRAM_PROT_EN
    chk_bus("p_user_e1", 1'b0, 2'd1);
    step();
    chk_bus("p_user_e2", 1'b1, 2'd1);
    step();
    drive(1'b1, TransNonseq, (MD - 1) * 4, 1'b0, SizeWord, 4'h1);
    step();
    idle();
    chk("p_user_rd", rd, 32'h12345678);
    step();
`else
    chk_bus("p_user", 1'b1, 2'd0);
    step();
    drive(1'b1, TransNonseq, (MD - 1) * 4, 1'b0, SizeWord, 4'h1);
    step();
    idle();
    chk("p_user_rd", rd, 32'hCAFEF00D);
    step();
`endif
    drive(1'b1, TransNonseq, (MD - 1) * 4, 1'b1, SizeWord, 4'h3);
    step();
    wdata = 32'h600DF00D;
    drive(1'b1, TransNonseq, (MD - 1) * 4, 1'b0, SizeWord, 4'h1);
    chk_bus("p_priv", 1'b1, 2'd0);
    step();
    idle();
    chk("p_priv_rd", rd, 32'h600DF00D);
    step();

    // Two wait states: write @0, read @0, then SEQ read taken in the ready cycle.
    tgt = 2'd2;
    drive(1'b1, TransNonseq, 32'h0, 1'b1, SizeWord, 4'h3);
    step();
    wdata = 32'h0BADF00D;
    idle();
    chk_bus("w2_c0", 1'b0, 2'd0);
    step();
    chk_bus("w2_c1", 1'b0, 2'd0);
    step();
    chk_bus("w2_c2", 1'b1, 2'd0);
    drive(1'b1, TransNonseq, 32'h0, 1'b0, SizeWord, 4'h3);
    step();
    chk_bus("r2_c0", 1'b0, 2'd0);
    drive(1'b1, TransSeq, 32'h4, 1'b0, SizeWord, 4'h3);
    step();
    chk_bus("r2_c1", 1'b0, 2'd0);
    step();
    chk_bus("r2_c2", 1'b1, 2'd0);
    chk("r2_data", rd, 32'h0BADF00D);
    step();
    idle();
    chk_bus("seq_acc", 1'b0, 2'd0);
    chk("r2_hold", rd, 32'h0BADF00D);
    step();
    step();
    chk_bus("seq_done", 1'b1, 2'd0);
    step();

    // Three wait states: reset mid-WAIT drops a pending write and clears hrdata.
    tgt = 2'd3;
    drive(1'b1, TransNonseq, 32'h8, 1'b1, SizeWord, 4'h3);
    step();
    wdata = 32'h33333333;
    idle();
    step();
    step();
    step();
    chk_bus("w3_done", 1'b1, 2'd0);
    step();
    drive(1'b1, TransNonseq, 32'h8, 1'b0, SizeWord, 4'h3);
    step();
    idle();
    step();
    step();
    step();
    chk("r3_data", rd, 32'h33333333);
    step();
    drive(1'b1, TransNonseq, 32'h8, 1'b1, SizeWord, 4'h3);
    step();
    wdata = 32'h22222222;
    idle();
    step();
    hreset = 1'b1;
    step();
    chk_bus("rst_mid", 1'b1, 2'd0);
    chk("rst_mid_hrdata", rd, 32'h0);
    hreset = 1'b0;
    step();
    drive(1'b1, TransNonseq, 32'h8, 1'b0, SizeWord, 4'h3);
    step();
    idle();
    step();
    step();
    step();
    chk("rst_dropped_wr", rd, 32'h33333333);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
